tm1638_ctrl: RTL
================

// Module: tm1638_ctrl
//
// PURPOSE
//   Sequencer for the TM1638 SPI transmitter. Holds a 16-byte shadow display RAM.
//   After reset it runs the init sequence: write mode, clear all 16 digits, display control.
//   It then streams only changed bytes and brightness/on-off changes to the SPI block,
//   one transaction at a time. Sits between user logic (digit/LED writers) and the spi instance.
//
// PARAMETERS
//   INIT_BRIGHTNESS  3'd7        brightness code used until user drives a different value
//   REFRESH_CYCLES   2_500_000   i_Clk cycles between forced full refreshes (TM1638_CTRL_REFRESH_EN only)
//
// PORTS
//   i_Clk             in   1   clock
//   i_Rst             in   1   synchronous reset, active-high
//   i_Wr_En           in   1   write shadow RAM this cycle
//   i_Wr_Addr         in   4   shadow RAM address (TM1638 display address 0..15)
//   i_Wr_Data         in   8   byte to display at i_Wr_Addr
//   i_Display_On      in   1   1 = display on, 0 = off
//   i_Brightness      in   3   TM1638 pulse-width code 0..7
//   i_SPI_Busy        in   1   from spi: high while a transaction is in progress
//   o_SPI_Data_Ready  out  1   one-cycle request pulse to spi
//   o_SPI_Data        out  18  {write=1, has_data, data[7:0], cmd[7:0]} to spi
//   o_Init_Done       out  1   high once the first display-control transaction completes
//   o_Idle            out  1   high when nothing is pending and the FSM is in S_IDLE
//   o_Err             out  1   sticky: spi failed to raise busy after a request
//
// BEHAVIOUR
// - Reset values:
//   - All outputs 0. o_SPI_Data = 18'h0.
//   - Shadow RAM = 8'h00 and all 16 dirty bits set.
//   - r_Mode_Pend = 1, r_Ctrl_Pend = 1, r_Ctrl_Sent = {1'b0, INIT_BRIGHTNESS}, round-robin pointer = 0.
// - Writes: i_Wr_En stores i_Wr_Data into RAM[i_Wr_Addr] and sets dirty[i_Wr_Addr].
//   - Writes are accepted in every state, including during init.
// - Control pending = r_Ctrl_Pend | ({i_Display_On, i_Brightness} != r_Ctrl_Sent).
// - FSM states:
//   - S_IDLE: select work with priority mode > data > ctrl.
//     - If any work is pending and i_SPI_Busy == 0, go to S_ISSUE. Otherwise stay.
//     - mode: cmd 8'h44 (write, fixed address), has_data = 0.
//     - data: first dirty address a, searching from the pointer upward with wrap 15 -> 0.
//       cmd = 8'hC0 | a, data = RAM[a], has_data = 1.
//     - ctrl: cmd = i_Display_On ? (8'h88 | i_Brightness) : 8'h80, has_data = 0.
//   - S_ISSUE (1 cycle): o_SPI_Data_Ready = 1 and o_SPI_Data holds the selected word (registered).
//     - Side effects on this edge:
//       - mode: r_Mode_Pend <= 0.
//       - data: dirty[a] <= 0; pointer <= a + 1 (4-bit wrap).
//       - ctrl: r_Ctrl_Sent <= inputs; r_Ctrl_Pend <= 0.
//     - Go to S_WAIT_HI.
//   - S_WAIT_HI: on i_SPI_Busy == 1, go to S_WAIT_LO.
//     - If busy is still 0 after 2 cycles: set o_Err and restore the pending flag of the issued item
//       (dirty[a], r_Mode_Pend or r_Ctrl_Pend). Go to S_IDLE.
//   - S_WAIT_LO: on i_SPI_Busy == 0, go to S_IDLE.
//     - If the item was ctrl, set o_Init_Done on this transition.
// - o_SPI_Data_Ready is high only in S_ISSUE. o_SPI_Data holds its value outside S_ISSUE.
// - Simultaneous events:
//   - A write to address a on the S_ISSUE edge that clears dirty[a]: the set wins. RAM takes the new
//     byte and a is re-sent later. The old byte already captured in o_SPI_Data is sent first.
//   - A ctrl input change on the S_ISSUE edge of a ctrl command: the old value is sent, and the
//     mismatch keeps control pending.
// - Mode command is sent once per reset. Data transactions never precede it.
// - Reset mid-transaction: the controller returns to its reset state and restarts the full init
//   sequence. spi shares i_Rst.
// - o_Idle = (state == S_IDLE) & ~mode_pend & ~|dirty & ~ctrl_pend.
// - Latency: pending work to o_SPI_Data_Ready = 2 cycles when spi is idle.
//
// CONFIGURATION
//   TM1638_CTRL_REFRESH_EN defined:
//   - A free-running counter of REFRESH_CYCLES sets all 16 dirty bits and r_Ctrl_Pend on wrap.
//   - This recovers the display after glitches.
//   - Counter resets to 0.
//   - A refresh coinciding with a user write is harmless: both only set bits.
//   TM1638_CTRL_REFRESH_EN undefined:
//   - No counter. Only user changes and reset generate traffic.
//
// TESTING (bench instantiates this block with spi CYCLES=1 plus a TM1638 serial monitor)
// 1. Reset, no writes -> transactions in order: 8'h44; 8'hC0..8'hCF each with data 8'h00;
//    then 8'h8F. o_Init_Done rises after 8'h8F; then o_Idle = 1.
// 2. After init, write addr 3 = 8'h3F -> exactly one transaction, cmd 8'hC3, data 8'h3F; o_Idle returns to 1.
// 3. Write addr 15 = 8'hAA then addr 0 = 8'h55 while busy with ptr = 15 ->
//    order is 8'hCF/AA, then 8'hC0/55 (wrap).
// 4. Write addr 5 = 8'h01 during S_ISSUE of addr 5 with old byte 8'h00 -> 8'hC5/00 sent,
//    then 8'hC5/01. Final RAM[5] = 8'h01.
// 5. Change brightness 7 -> 2, then display off -> 8'h8A, then 8'h80. Toggling the same
//    value back before issue -> no transaction.
// 6. Tie i_SPI_Busy = 0 -> o_Err = 1 after S_ISSUE + 2 cycles. Item retried. Assert i_Rst mid-transfer ->
//    all outputs 0 next cycle; init sequence restarts with 8'h44.

Source files
------------

// File: rtl/tm1638_ctrl.sv
// TM1638 transaction sequencer.
// Keeps a 16-byte shadow of the display RAM. After reset it sends the write-mode
// command, every digit and then display control. After that it sends only the
// bytes that changed and any display on/off or brightness change, one SPI
// transaction at a time.
// Optional periodic full refresh: define TM1638_CTRL_REFRESH_EN.
module tm1638_ctrl #(
  parameter logic [2:0]  INIT_BRIGHTNESS = 3'd7,
  parameter int unsigned REFRESH_CYCLES  = 2_500_000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Wr_En,
  input  logic [3:0]  i_Wr_Addr,
  input  logic [7:0]  i_Wr_Data,
  input  logic        i_Display_On,
  input  logic [2:0]  i_Brightness,
  input  logic        i_SPI_Busy,
  output logic        o_SPI_Data_Ready,
  output logic [17:0] o_SPI_Data,
  output logic        o_Init_Done,
  output logic        o_Idle,
  output logic        o_Err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO} state_t;
  typedef enum logic [1:0] {K_MODE, K_DATA, K_CTRL} kind_t;

  state_t      r_State, w_Next;
  logic [7:0]  r_Ram [16];
  logic [15:0] r_Dirty;
  logic        r_Mode_Pend;
  logic        r_Ctrl_Pend;
  logic [3:0]  r_Ctrl_Sent;
  logic [3:0]  r_Ctrl_Snap;
  logic [3:0]  r_Ptr;
  kind_t       r_Kind;
  logic [3:0]  r_Addr;
  logic        r_Wait_Cnt;
  logic [17:0] r_SPI_Data;
  logic        r_Init_Done;
  logic        r_Err;

  logic [3:0]  w_Ctrl_Now;
  logic        w_Ctrl_Pend;
  logic        w_Found;
  logic [3:0]  w_Sel_Addr;
  logic        w_Work;
  kind_t       w_Sel_Kind;
  logic [17:0] w_Sel_Word;
  logic        w_Timeout;
  logic        w_Refresh;

  assign w_Ctrl_Now  = {i_Display_On, i_Brightness};
  assign w_Ctrl_Pend = r_Ctrl_Pend | (w_Ctrl_Now != r_Ctrl_Sent);
  assign w_Work      = r_Mode_Pend | w_Found | w_Ctrl_Pend;
  assign w_Timeout   = (r_State == S_WAIT_HI) & ~i_SPI_Busy & r_Wait_Cnt;

`ifdef TM1638_CTRL_REFRESH_EN
  localparam int unsigned CntW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  logic [CntW-1:0] r_Refresh_Cnt;

  assign w_Refresh = (r_Refresh_Cnt == CntW'(REFRESH_CYCLES - 1));

  // Free-running refresh timer; its wrap marks everything for resend.
  always_ff @(posedge i_Clk) begin
    if (i_Rst || w_Refresh) r_Refresh_Cnt <= '0;
    else                    r_Refresh_Cnt <= r_Refresh_Cnt + 1'b1;
  end
`else
  assign w_Refresh = 1'b0;
`endif

  // Round-robin search for the first dirty address at or above the pointer.
  always_comb begin
    logic [3:0] idx;
    w_Found    = 1'b0;
    w_Sel_Addr = 4'h0;
    idx        = 4'h0;
    for (int i = 0; i < 16; i++) begin
      idx = r_Ptr + 4'(i);
      if (!w_Found && r_Dirty[idx]) begin
        w_Found    = 1'b1;
        w_Sel_Addr = idx;
      end
    end
  end

  // Work selection: mode command first, then data, then display control.
  always_comb begin
    w_Sel_Kind = K_CTRL;
    w_Sel_Word = {1'b1, 1'b0, 8'h00, (i_Display_On ? (8'h88 | {5'b0, i_Brightness}) : 8'h80)};
    if (r_Mode_Pend) begin
      w_Sel_Kind = K_MODE;
      w_Sel_Word = {1'b1, 1'b0, 8'h00, 8'h44};
    end else if (w_Found) begin
      w_Sel_Kind = K_DATA;
      w_Sel_Word = {1'b1, 1'b1, r_Ram[w_Sel_Addr], 8'hC0 | {4'h0, w_Sel_Addr}};
    end
  end

  // State register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) r_State <= S_IDLE;
    else       r_State <= w_Next;
  end

  // Next-state logic.
  always_comb begin
    w_Next = r_State;
    unique case (r_State)
      S_IDLE:    if (w_Work && !i_SPI_Busy) w_Next = S_ISSUE;
      S_ISSUE:   w_Next = S_WAIT_HI;
      S_WAIT_HI: begin
        if (i_SPI_Busy)      w_Next = S_WAIT_LO;
        else if (r_Wait_Cnt) w_Next = S_IDLE;
      end
      S_WAIT_LO: if (!i_SPI_Busy) w_Next = S_IDLE;
      default:   w_Next = S_IDLE;
    endcase
  end

  // FSM-decoded outputs.
  always_comb begin
    o_SPI_Data_Ready = (r_State == S_ISSUE);
    o_Idle           = (r_State == S_IDLE) & ~r_Mode_Pend & ~|r_Dirty & ~w_Ctrl_Pend;
  end

  assign o_SPI_Data  = r_SPI_Data;
  assign o_Init_Done = r_Init_Done;
  assign o_Err       = r_Err;

  // Shadow RAM, pending flags and the captured transaction. Later assignments
  // win, so user writes and refresh always override a clear on the same edge.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      for (int i = 0; i < 16; i++) r_Ram[i] <= 8'h00;
      r_Dirty     <= 16'hFFFF;
      r_Mode_Pend <= 1'b1;
      r_Ctrl_Pend <= 1'b1;
      r_Ctrl_Sent <= {1'b0, INIT_BRIGHTNESS};
      r_Ctrl_Snap <= 4'h0;
      r_Ptr       <= 4'h0;
      r_Kind      <= K_MODE;
      r_Addr      <= 4'h0;
      r_Wait_Cnt  <= 1'b0;
      r_SPI_Data  <= 18'h0;
      r_Init_Done <= 1'b0;
      r_Err       <= 1'b0;
    end else begin
      if (r_State == S_IDLE && w_Next == S_ISSUE) begin
        r_SPI_Data  <= w_Sel_Word;
        r_Kind      <= w_Sel_Kind;
        r_Addr      <= w_Sel_Addr;
        // Remember what was actually sent so a change during issue stays pending.
        r_Ctrl_Snap <= w_Ctrl_Now;
        r_Wait_Cnt  <= 1'b0;
      end
      if (r_State == S_ISSUE) begin
        unique case (r_Kind)
          K_MODE: r_Mode_Pend <= 1'b0;
          K_DATA: begin
            r_Dirty[r_Addr] <= 1'b0;
            r_Ptr           <= r_Addr + 4'h1;
          end
          K_CTRL: begin
            r_Ctrl_Sent <= r_Ctrl_Snap;
            r_Ctrl_Pend <= 1'b0;
          end
          default: ;
        endcase
      end
      if (r_State == S_WAIT_HI && !i_SPI_Busy) r_Wait_Cnt <= 1'b1;
      if (w_Timeout) begin
        r_Err <= 1'b1;
        unique case (r_Kind)
          K_MODE:  r_Mode_Pend     <= 1'b1;
          K_DATA:  r_Dirty[r_Addr] <= 1'b1;
          K_CTRL:  r_Ctrl_Pend     <= 1'b1;
          default: ;
        endcase
      end
      if (r_State == S_WAIT_LO && !i_SPI_Busy && r_Kind == K_CTRL) r_Init_Done <= 1'b1;
      if (w_Refresh) begin
        r_Dirty     <= 16'hFFFF;
        r_Ctrl_Pend <= 1'b1;
      end
      if (i_Wr_En) begin
        r_Ram[i_Wr_Addr]   <= i_Wr_Data;
        r_Dirty[i_Wr_Addr] <= 1'b1;
      end
    end
  end

endmodule
